// File: rtl/ksa.sv
// ksa: ARC4 key-scheduling engine that permutes the 256x8 S memory in place
module ksa #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             addr,
    input  logic [7:0]             rddata,
    output logic [7:0]             wrdata,
    output logic                   wren
);
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0] KLAST = KW'(KEY_BYTES - 1);

    typedef enum logic [2:0] {IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_i;
    logic [7:0]    r_j;
    logic [7:0]    r_si;
    logic [7:0]    r_sj;
    logic [KW-1:0] r_kidx;
    logic [7:0]    w_kbyte;

    // Select the key byte for the current i; byte 0 sits in the most significant position
    always_comb begin
        w_kbyte = key[8*(KEY_BYTES-1-int'(r_kidx)) +: 8];
    end

    // State register; reset aborts any run in progress
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Datapath: indices, captured S values and the key byte counter (tracks i mod KEY_BYTES)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i    <= '0;
            r_j    <= '0;
            r_si   <= '0;
            r_sj   <= '0;
            r_kidx <= '0;
        end else begin
            case (r_state)
                IDLE: if (en) begin
                    r_i    <= '0;
                    r_j    <= '0;
                    r_kidx <= '0;
                end
                WT_I: begin
                    r_si <= rddata;
                    r_j  <= r_j + rddata + w_kbyte;
                end
                WT_J: r_sj <= rddata;
                WR_J: begin
                    r_i    <= r_i + 8'd1;
                    r_kidx <= (r_kidx == KLAST) ? '0 : r_kidx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state and memory-port decode; i wraps to 0 as the last swap completes
    always_comb begin
        w_next = r_state;
        rdy    = 1'b0;
        addr   = r_i;
        wrdata = 8'd0;
        wren   = 1'b0;
        case (r_state)
            IDLE: begin
                rdy    = 1'b1;
                w_next = en ? RD_I : IDLE;
            end
            RD_I: w_next = WT_I;
            WT_I: w_next = RD_J;
            RD_J: begin
                addr   = r_j;
                w_next = WT_J;
            end
            WT_J: w_next = WR_I;
            WR_I: begin
                wrdata = r_sj;
                wren   = 1'b1;
                w_next = WR_J;
            end
            WR_J: begin
                addr   = r_j;
                wrdata = r_si;
                wren   = 1'b1;
                w_next = (r_i == 8'd255) ? IDLE : RD_I;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule
